burst_fetch_arbiter: RTL and testbench

- Shares one DRAM read port (AR + R, no rready; beats accepted every cycle) among NCH fetch clients.
- Clients are input buffer, weight buffer, and future pointwise/bias buffers.
- Per-channel address and burst requests, round-robin arbitration, one outstanding burst at a time.
- Read beats routed back to the owning channel with beat counting and burst-length checking.
- Sits inside the data path, between the buffers and the DRAM read master.

---
 rtl/burst_fetch_arbiter_if.sv | 37 +++
 rtl/burst_fetch_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_burst_fetch_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_fetch_arbiter_if.sv
// DRAM read-port bundle (AR + R channels, no rready) shared by the fetch arbiter.
// The arbiter drives the address side through the master modport; the memory side
// uses the slave modport.
interface burst_fetch_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic [AW-1:0] araddr;
  logic [3:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rlast;

  modport master (
    output araddr,
    output arburst,
    output arvalid,
    input  arready,
    input  rdata,
    input  rvalid,
    input  rlast
  );

  modport slave (
    input  araddr,
    input  arburst,
    input  arvalid,
    output arready,
    output rdata,
    output rvalid,
    output rlast
  );

endinterface

// File: rtl/burst_fetch_arbiter.sv
// Burst fetch arbiter: shares one DRAM read port among NCH fetch clients.
// Round-robin grant, one outstanding burst, read beats registered and routed back to
// the owning channel, sticky beat-count error against BURST.
// Optional watchdog abort on stalled bursts when FETCH_TIMEOUT_EN is defined
// (adds the TIMEOUT parameter and the timeout_err port).
module burst_fetch_arbiter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned NCH   = 2,
  parameter int unsigned BURST = 32,
`ifdef FETCH_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 1024,
`endif
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_req,
  input  logic [AW-1:0]         ch_addr [NCH],
  input  logic [3:0]            ch_burst [NCH],
  output logic [NCH-1:0]        ch_gnt,
  output logic [DW-1:0]         ch_rdata,
  output logic [NCH-1:0]        ch_rvalid,
  output logic [NCH-1:0]        ch_rlast,
  burst_fetch_arbiter_if.master dram,
  output logic                  busy,
  output logic [CW-1:0]         cur_ch,
  output logic                  burst_err,
  input  logic                  err_clr
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  // Beat counter saturates at BURST+1 so an over-long burst can never alias to BURST.
  localparam int unsigned BCW = $clog2(BURST + 2);

  state_e         state_q;
  logic [CW-1:0]  cur_ch_q;
  logic [CW-1:0]  rr_ptr_q;
  logic [AW-1:0]  araddr_q;
  logic [3:0]     arburst_q;
  logic           arvalid_q;
  logic [DW-1:0]  rdata_q;
  logic [NCH-1:0] rvalid_q;
  logic [NCH-1:0] rlast_q;
  logic [BCW-1:0] beat_cnt_q;
  logic           burst_err_q;

  logic           pick_valid;
  logic [CW-1:0]  pick_ch;
  logic [CW:0]    arb_sum;
  logic [CW:0]    ptr_sum;
  logic [CW-1:0]  next_ptr;
  logic [BCW-1:0] beat_num;
  logic           ar_hs;
  logic           data_beat;
  logic           beat_err;
  logic           abort;

  // Round-robin pick: first requesting channel at or after the pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    arb_sum    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      arb_sum = {1'b0, rr_ptr_q} + (CW + 1)'(i);
      if (arb_sum >= (CW + 1)'(NCH)) begin
        arb_sum = arb_sum - (CW + 1)'(NCH);
      end
      if (!pick_valid && ch_req[arb_sum[CW-1:0]]) begin
        pick_valid = 1'b1;
        pick_ch    = arb_sum[CW-1:0];
      end
    end
  end

  // Pointer after a grant: the channel following the granted one, modulo NCH.
  always_comb begin
    ptr_sum = {1'b0, cur_ch_q} + (CW + 1)'(1);
    if (ptr_sum >= (CW + 1)'(NCH)) begin
      ptr_sum = ptr_sum - (CW + 1)'(NCH);
    end
    next_ptr = ptr_sum[CW-1:0];
  end

  assign ar_hs     = arvalid_q & dram.arready;
  assign data_beat = (state_q == StData) & dram.rvalid;
  assign beat_num  = (beat_cnt_q == BCW'(BURST + 1)) ? beat_cnt_q : beat_cnt_q + 1'b1;
  // Error on rlast at the wrong count, or on reaching BURST without rlast.
  assign beat_err  = data_beat & (dram.rlast ? (beat_num != BCW'(BURST))
                                             : (beat_num == BCW'(BURST)));

  // Grant pulse coincides with the AR handshake of the owning channel.
  always_comb begin
    ch_gnt = '0;
    if (ar_hs) begin
      ch_gnt[cur_ch_q] = 1'b1;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wdog_q;
  logic          wd_kick;
  logic          timeout_err_q;

  assign wd_kick = ((state_q == StAddr) & dram.arready) | ((state_q == StData) & dram.rvalid);
  assign abort   = (state_q != StIdle) & ~wd_kick & ((wdog_q + 1'b1) == TW'(TIMEOUT));

  // Watchdog: counts stalled cycles of an active burst; sticky flag when it expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) || wd_kick || abort) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (abort) begin
        timeout_err_q <= 1'b1;
      end else if (err_clr) begin
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign abort = 1'b0;
`endif

  // Main FSM with registered AR outputs, beat routing, counting and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_ch_q    <= '0;
      rr_ptr_q    <= '0;
      araddr_q    <= '0;
      arburst_q   <= '0;
      arvalid_q   <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
      rlast_q     <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      rvalid_q <= '0;
      rlast_q  <= '0;
      // Set wins over a coincident clear.
      if (beat_err) begin
        burst_err_q <= 1'b1;
      end else if (err_clr) begin
        burst_err_q <= 1'b0;
      end
      if (abort) begin
        // Aborted burst: close it out with a bare rlast to the owner.
        state_q           <= StIdle;
        arvalid_q         <= 1'b0;
        rlast_q[cur_ch_q] <= 1'b1;
        beat_cnt_q        <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pick_valid) begin
              cur_ch_q  <= pick_ch;
              araddr_q  <= ch_addr[pick_ch];
              arburst_q <= ch_burst[pick_ch];
              arvalid_q <= 1'b1;
              state_q   <= StAddr;
            end
          end
          StAddr: begin
            if (dram.arready) begin
              arvalid_q  <= 1'b0;
              rr_ptr_q   <= next_ptr;
              beat_cnt_q <= '0;
              state_q    <= StData;
            end
          end
          StData: begin
            if (dram.rvalid) begin
              rdata_q            <= dram.rdata;
              rvalid_q[cur_ch_q] <= 1'b1;
              rlast_q[cur_ch_q]  <= dram.rlast;
              if (dram.rlast) begin
                beat_cnt_q <= '0;
                state_q    <= StIdle;
              end else begin
                beat_cnt_q <= beat_num;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign dram.araddr  = araddr_q;
  assign dram.arburst = arburst_q;
  assign dram.arvalid = arvalid_q;
  assign ch_rdata     = rdata_q;
  assign ch_rvalid    = rvalid_q;
  assign ch_rlast     = rlast_q;
  assign busy         = (state_q != StIdle);
  assign cur_ch       = cur_ch_q;
  assign burst_err    = burst_err_q;

endmodule

// File: tb/tb_burst_fetch_arbiter.sv
// Self-checking bench for burst_fetch_arbiter. The bench plays the DRAM slave and
// the clients; expectations come from a round-robin pointer, a sticky error flag
// and per-beat data predictions kept in the bench.
module tb_burst_fetch_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned NCH   = 2;
  localparam int unsigned BURST = 32;
  localparam int unsigned CW    = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_req;
  logic [AW-1:0]  ch_addr [NCH];
  logic [3:0]     ch_burst [NCH];
  logic [NCH-1:0] ch_gnt;
  logic [DW-1:0]  ch_rdata;
  logic [NCH-1:0] ch_rvalid;
  logic [NCH-1:0] ch_rlast;
  logic           busy;
  logic [CW-1:0]  cur_ch;
  logic           burst_err;
  logic           err_clr;
`ifdef FETCH_TIMEOUT_EN
  logic           timeout_err;
`endif

  burst_fetch_arbiter_if #(.AW(AW), .DW(DW)) dram ();

  burst_fetch_arbiter #(
    .DW(DW),
    .AW(AW),
    .NCH(NCH),
`ifdef FETCH_TIMEOUT_EN
    .TIMEOUT(16),
`endif
    .BURST(BURST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_req(ch_req),
    .ch_addr(ch_addr),
    .ch_burst(ch_burst),
    .ch_gnt(ch_gnt),
    .ch_rdata(ch_rdata),
    .ch_rvalid(ch_rvalid),
    .ch_rlast(ch_rlast),
    .dram(dram),
    .busy(busy),
    .cur_ch(cur_ch),
    .burst_err(burst_err),
`ifdef FETCH_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ptr    = 0;   // model round-robin pointer
  bit exp_err = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick();
    for (int i = 0; i < NCH; i++) begin
      if (ch_req[(ptr + i) % NCH]) return (ptr + i) % NCH;
    end
    return 0;
  endfunction

  // Serve one burst for whichever channel the model expects to win.
  task automatic do_burst(input int nbeats, input int ar_stall, input bit keep_req,
                          output int lat);
    int ch;
    logic [DW-1:0]  d;
    logic [AW-1:0]  a0;
    logic [NCH-1:0] ev;
    logic [NCH-1:0] el;
    lat = 0;
    ch  = model_pick();
    ev  = '0;
    ev[ch] = 1'b1;
    while (dram.arvalid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    checks++;
    if (dram.arvalid !== 1'b1) begin
      $display("FAIL arvalid_wait: arvalid=%b after %0d cycles, need 1", dram.arvalid, lat);
      return;
    end else passes++;
    checks++;
    if (cur_ch !== CW'(ch)) $display("FAIL cur_ch: got %0d need %0d", cur_ch, ch);
    else passes++;
    checks++;
    if (dram.araddr !== ch_addr[ch] || dram.arburst !== ch_burst[ch])
      $display("FAIL ar_fields: got addr %h burst %h need addr %h burst %h",
               dram.araddr, dram.arburst, ch_addr[ch], ch_burst[ch]);
    else passes++;
    a0 = dram.araddr;
    for (int s = 0; s < ar_stall; s++) begin
      dram.arready = 1'b0;
      #1;
      checks++;
      if (ch_gnt !== '0 || dram.arvalid !== 1'b1 || dram.araddr !== a0)
        $display("FAIL ar_stall: got gnt %b arvalid %b addr %h need gnt 0 arvalid 1 addr %h",
                 ch_gnt, dram.arvalid, dram.araddr, a0);
      else passes++;
      tick();
    end
    dram.arready = 1'b1;
    #1;
    checks++;
    if (ch_gnt !== ev) $display("FAIL gnt: got %b need %b", ch_gnt, ev);
    else passes++;
    if (!keep_req) ch_req[ch] = 1'b0;
    ptr = (ch + 1) % NCH;
    tick();
    dram.arready = 1'b0;
    checks++;
    if (ch_gnt !== '0 || dram.arvalid !== 1'b0 || ch_rvalid !== '0)
      $display("FAIL post_grant: got gnt %b arvalid %b rvalid %b need 0 0 0",
               ch_gnt, dram.arvalid, ch_rvalid);
    else passes++;
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, 2)) begin
        dram.rvalid = 1'b0;
        dram.rlast  = 1'b0;
        tick();
        checks++;
        if (ch_rvalid !== '0 || ch_rlast !== '0)
          $display("FAIL beat_gap: got rvalid %b rlast %b need 0 0", ch_rvalid, ch_rlast);
        else passes++;
      end
      d = $urandom;
      dram.rvalid = 1'b1;
      dram.rdata  = d;
      dram.rlast  = (b == nbeats - 1);
      el = (b == nbeats - 1) ? ev : '0;
      tick();
      checks++;
      if (ch_rvalid !== ev || ch_rdata !== d || ch_rlast !== el)
        $display("FAIL beat %0d: got rvalid %b data %h rlast %b need %b %h %b",
                 b, ch_rvalid, ch_rdata, ch_rlast, ev, d, el);
      else passes++;
    end
    dram.rvalid = 1'b0;
    dram.rlast  = 1'b0;
    if (nbeats != BURST) exp_err = 1'b1;
    checks++;
    if (busy !== 1'b0 || burst_err !== exp_err)
      $display("FAIL burst_end: got busy %b err %b need busy 0 err %b", busy, burst_err, exp_err);
    else passes++;
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || dram.arvalid !== 1'b0 || cur_ch !== '0 || burst_err !== 1'b0 ||
        ch_rvalid !== '0 || ch_rlast !== '0 || ch_gnt !== '0 || ch_rdata !== '0 ||
        dram.araddr !== '0 || dram.arburst !== '0)
      $display("FAIL reset: got busy %b arvalid %b cur %0d err %b rv %b rl %b gnt %b data %h need all 0",
               busy, dram.arvalid, cur_ch, burst_err, ch_rvalid, ch_rlast, ch_gnt, ch_rdata);
    else passes++;
  endtask

  task automatic test_single;
    int lat;
    ch_addr[0]   = 32'h0000_1000;
    ch_burst[0]  = 4'h1;
    ch_req[0]    = 1'b1;
    dram.arready = 1'b1;
    do_burst(BURST, 0, 1'b0, lat);
    checks++;
    if (lat != 1) $display("FAIL req_latency: got %0d cycles need 1", lat);
    else passes++;
  endtask

  task automatic test_backpressure;
    int lat;
    ch_addr[0]  = 32'h0000_2040;
    ch_burst[0] = 4'h2;
    ch_req[0]   = 1'b1;
    // Stray beats while IDLE/ADDR must be ignored.
    dram.rvalid = 1'b1;
    dram.rdata  = 32'hdead_beef;
    do_burst(BURST, 5, 1'b0, lat);
  endtask

  task automatic test_short_burst;
    int lat;
    ch_addr[1] = 32'h0000_3000;
    ch_req[1]  = 1'b1;
    do_burst(BURST - 1, 0, 1'b0, lat);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    checks++;
    if (burst_err !== 1'b0) $display("FAIL err_clr: got %b need 0", burst_err);
    else passes++;
    // err_clr held through a short burst: the set on rlast wins.
    ch_req[0] = 1'b1;
    err_clr   = 1'b1;
    do_burst(BURST - 1, 0, 1'b0, lat);
    err_clr = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    checks++;
    if (burst_err !== 1'b0) $display("FAIL err_clr2: got %b need 0", burst_err);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int lat;
    ch_req[0]  = 1'b1;
    ch_addr[0] = 32'h0000_4000;
    lat = 0;
    while (dram.arvalid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    dram.arready = 1'b1;
    tick();
    dram.arready = 1'b0;
    ch_req[0]    = 1'b0;
    for (int b = 0; b < 10; b++) begin
      dram.rvalid = 1'b1;
      dram.rdata  = $urandom;
      tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dram.arvalid !== 1'b0 || ch_rvalid !== '0 || ch_rlast !== '0 ||
        cur_ch !== '0 || ch_rdata !== '0 || burst_err !== 1'b0 || ch_gnt !== '0)
      $display("FAIL reset_mid: got busy %b arvalid %b rv %b rl %b cur %0d data %h need all 0",
               busy, dram.arvalid, ch_rvalid, ch_rlast, cur_ch, ch_rdata);
    else passes++;
    ptr     = 0;
    exp_err = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (ch_rvalid !== '0 || busy !== 1'b0)
      $display("FAIL inflight_beat: got rvalid %b busy %b need 0 0", ch_rvalid, busy);
    else passes++;
    dram.rvalid = 1'b0;
    ch_addr[1]  = 32'h0000_5000;
    ch_req[1]   = 1'b1;
    do_burst(BURST, 0, 1'b0, lat);
  endtask

  task automatic test_contention;
    int lat;
    ch_addr[0] = 32'h0001_0000;
    ch_addr[1] = 32'h0002_0000;
    ch_req     = 2'b11;
    for (int k = 0; k < 4; k++) begin
      do_burst(BURST, $urandom_range(0, 2), 1'b1, lat);
    end
    ch_req = '0;
  endtask

  task automatic test_random;
    int lat;
    int nb;
    int r;
    bit clr;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!ch_req[c] && ($urandom_range(0, 1) == 1)) begin
          ch_addr[c]  = $urandom;
          ch_burst[c] = 4'($urandom_range(0, 15));
          ch_req[c]   = 1'b1;
        end
      end
      if (ch_req == '0) begin
        r = $urandom_range(0, NCH - 1);
        ch_addr[r] = $urandom;
        ch_req[r]  = 1'b1;
      end
      r  = $urandom_range(0, 5);
      nb = (r == 0) ? BURST - 1 : (r == 1) ? BURST + 1 : (r == 2) ? 1 : BURST;
      clr = ($urandom_range(0, 1) == 1);
      err_clr = clr;
      if (clr) exp_err = 1'b0;
      do_burst(nb, $urandom_range(0, 3), 1'b0, lat);
      err_clr = 1'b0;
    end
    ch_req = '0;
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout;
    int lat;
    int ch;
    logic [NCH-1:0] ev;
    ch_req[0] = 1'b1;
    ch  = model_pick();
    ev  = '0;
    ev[ch] = 1'b1;
    lat = 0;
    while (dram.arvalid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    dram.arready = 1'b1;
    tick();
    dram.arready = 1'b0;
    ch_req[0]    = 1'b0;
    ptr          = (ch + 1) % NCH;
    dram.rvalid  = 1'b0;
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL pre_timeout: got busy %b terr %b need 1 0", busy, timeout_err);
    else passes++;
    tick();
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || ch_rlast !== ev || ch_rvalid !== '0)
      $display("FAIL timeout: got busy %b terr %b rlast %b rvalid %b need 0 1 %b 0",
               busy, timeout_err, ch_rlast, ch_rvalid, ev);
    else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clr: got %b need 0", timeout_err);
    else passes++;
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    ch_req       = '0;
    err_clr      = 1'b0;
    dram.arready = 1'b0;
    dram.rvalid  = 1'b0;
    dram.rlast   = 1'b0;
    dram.rdata   = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_addr[c]  = '0;
      ch_burst[c] = '0;
    end
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_backpressure();
    test_short_burst();
    test_reset_mid();
    test_contention();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
